// File: rtl/pea_pkg.sv
// Shared types and constants for the PE array (PEA) and its context sequencer.
// Ports: none (package).
package pea_pkg;

    // Array geometry and per-PE configuration word width
    localparam int M             = 4;
    localparam int N             = 4;
    localparam int LOG_M         = 2;
    localparam int LOG_N         = 2;
    localparam int N_PE          = M * N;
    localparam int N_CFG_BITS_PE = 16;

    // Context sequencer defaults
    localparam int N_CTX_DEFAULT        = 4;
    localparam int DRAIN_CYCLES_DEFAULT = 2;
    localparam int ITER_W_DEFAULT       = 16;

    // One PE configuration word
    typedef logic [N_CFG_BITS_PE-1:0] pe_cfg_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } ctx_state_t;

    // Width of a context index; never less than one bit
    function automatic int ctx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pea_ctx_ctrl_if.sv
// Host/config bus and PEA control bundle for the context sequencer.
// Ports (signals):
//   cfg_we_i / cfg_len_we_i / cfg_ctx_i / cfg_pe_i / cfg_wdata_i / cfg_len_i : context writes
//   cfg_err_o   : pulse, write rejected
//   start_i / n_ctx_i / abort_i : sequence control
//   iter_done_i : PEA iteration-complete pulse
//   pe_cfg_o / cfg_load_o / pea_en_o / ctx_idx_o / busy_o / done_o : sequencer outputs
// Modports: master drives the inputs of the sequencer, slave is the sequencer.
interface pea_ctx_ctrl_if
    import pea_pkg::*;
#(
    parameter int N_CTX  = N_CTX_DEFAULT,
    parameter int ITER_W = ITER_W_DEFAULT
);
    localparam int CTX_W  = ctx_w(N_CTX);
    localparam int NCTX_W = $clog2(N_CTX) + 1;

    logic                             cfg_we_i;
    logic                             cfg_len_we_i;
    logic [CTX_W-1:0]                 cfg_ctx_i;
    logic [LOG_M+LOG_N-1:0]           cfg_pe_i;
    pe_cfg_t                          cfg_wdata_i;
    logic [ITER_W-1:0]                cfg_len_i;
    logic                             cfg_err_o;
    logic                             start_i;
    logic [NCTX_W-1:0]                n_ctx_i;
    logic                             abort_i;
    logic                             iter_done_i;
    logic [N_PE*N_CFG_BITS_PE-1:0]    pe_cfg_o;
    logic                             cfg_load_o;
    logic                             pea_en_o;
    logic [CTX_W-1:0]                 ctx_idx_o;
    logic                             busy_o;
    logic                             done_o;

    modport master (
        output cfg_we_i, cfg_len_we_i, cfg_ctx_i, cfg_pe_i, cfg_wdata_i, cfg_len_i,
        output start_i, n_ctx_i, abort_i, iter_done_i,
        input  cfg_err_o, pe_cfg_o, cfg_load_o, pea_en_o, ctx_idx_o, busy_o, done_o
    );

    modport slave (
        input  cfg_we_i, cfg_len_we_i, cfg_ctx_i, cfg_pe_i, cfg_wdata_i, cfg_len_i,
        input  start_i, n_ctx_i, abort_i, iter_done_i,
        output cfg_err_o, pe_cfg_o, cfg_load_o, pea_en_o, ctx_idx_o, busy_o, done_o
    );

endinterface

// File: rtl/pea_ctx_store.sv
// Context register file: N_CTX contexts of N_PE config words plus an iteration
// count per context. Single write port, combinational full-context read.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset (words 0, lengths 1)
//   we, len_we        : write a PE word / a context length (may coincide)
//   wr_ctx, wr_pe     : write target
//   wr_data, wr_len   : write data (length 0 is stored as 1)
//   rd_ctx            : read context select
//   rd_cfg, rd_len    : selected context words (PE k at [k*16 +: 16]) and length
module pea_ctx_store
    import pea_pkg::*;
#(
    parameter int N_CTX  = N_CTX_DEFAULT,
    parameter int ITER_W = ITER_W_DEFAULT,
    localparam int CTX_W = ctx_w(N_CTX)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          we,
    input  logic                          len_we,
    input  logic [CTX_W-1:0]              wr_ctx,
    input  logic [LOG_M+LOG_N-1:0]        wr_pe,
    input  pe_cfg_t                       wr_data,
    input  logic [ITER_W-1:0]             wr_len,
    input  logic [CTX_W-1:0]              rd_ctx,
    output logic [N_PE*N_CFG_BITS_PE-1:0] rd_cfg,
    output logic [ITER_W-1:0]             rd_len
);

    pe_cfg_t           words [N_CTX][N_PE];
    logic [ITER_W-1:0] lens  [N_CTX];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < N_CTX; c++) begin
                lens[c] <= ITER_W'(1);
                for (int k = 0; k < N_PE; k++) begin
                    words[c][k] <= '0;
                end
            end
        end else begin
            if (we && (int'(wr_ctx) < N_CTX)) begin
                words[wr_ctx][wr_pe] <= wr_data;
            end
            // A zero length would never terminate RUN, so clamp it to one iteration
            if (len_we && (int'(wr_ctx) < N_CTX)) begin
                lens[wr_ctx] <= (wr_len == '0) ? ITER_W'(1) : wr_len;
            end
        end
    end

    always_comb begin
        rd_cfg = '0;
        for (int k = 0; k < N_PE; k++) begin
            rd_cfg[k*N_CFG_BITS_PE +: N_CFG_BITS_PE] = words[rd_ctx][k];
        end
        rd_len = lens[rd_ctx];
    end

endmodule

// File: rtl/pea_ctx_ctrl.sv
// Context sequencer for the MxN PEA. On start it walks contexts 0..n-1: loads
// each context's configuration, enables the array for its iteration count,
// drains DRAIN_CYCLES idle cycles, then moves on; finishes with a done pulse.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : pea_ctx_ctrl_if.slave (config bus, sequence control, PEA outputs)
// All outputs are registered.
module pea_ctx_ctrl
    import pea_pkg::*;
#(
    parameter int N_CTX        = N_CTX_DEFAULT,
    parameter int ITER_W       = ITER_W_DEFAULT,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pea_ctx_ctrl_if.slave  bus
);

    localparam int CTX_W = ctx_w(N_CTX);

    ctx_state_t                    state_q, state_d;
    logic [CTX_W-1:0]              ctx_q, last_q, last_d, load_ctx;
    logic [ITER_W-1:0]             iter_q, len_q;
    logic [15:0]                   drain_q;
    logic                          start_acc, wr_ok, iter_last, ctx_end;
    logic                          cfg_load_d, pea_en_d, busy_d, done_d, err_d;
    logic [N_PE*N_CFG_BITS_PE-1:0] rd_cfg;
    logic [ITER_W-1:0]             rd_len;

    // Writes only land in IDLE, and not in the cycle that starts a sequence
    pea_ctx_store #(.N_CTX(N_CTX), .ITER_W(ITER_W)) u_store (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we      (bus.cfg_we_i && wr_ok),
        .len_we  (bus.cfg_len_we_i && wr_ok),
        .wr_ctx  (bus.cfg_ctx_i),
        .wr_pe   (bus.cfg_pe_i),
        .wr_data (bus.cfg_wdata_i),
        .wr_len  (bus.cfg_len_i),
        .rd_ctx  (load_ctx),
        .rd_cfg  (rd_cfg),
        .rd_len  (rd_len)
    );

    always_comb begin
        start_acc = (state_q == IDLE) && bus.start_i && (bus.n_ctx_i != '0);
        wr_ok     = (state_q == IDLE) && !start_acc;
        // Context about to be loaded: 0 when starting, else the successor
        load_ctx  = (state_q == IDLE) ? '0 : CTX_W'(ctx_q + 1'b1);
        iter_last = bus.iter_done_i && (iter_q == len_q - 1'b1);
        ctx_end   = (ctx_q == last_q);
        if (int'(bus.n_ctx_i) > N_CTX) last_d = CTX_W'(N_CTX - 1);
        else                           last_d = CTX_W'(bus.n_ctx_i - 1'b1);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; abort wins over everything outside IDLE
    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && bus.abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start_acc) state_d = LOAD;
                LOAD:  state_d = RUN;
                RUN:   if (iter_last) begin
                           if (DRAIN_CYCLES == 0) state_d = ctx_end ? DONE : LOAD;
                           else                   state_d = DRAIN;
                       end
                DRAIN: if (drain_q == 16'(DRAIN_CYCLES - 1)) state_d = ctx_end ? DONE : LOAD;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        cfg_load_d = (state_d == LOAD);
        pea_en_d   = (state_d == RUN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        err_d      = (bus.cfg_we_i || bus.cfg_len_we_i) && !wr_ok;
    end

    // Sequencing counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctx_q          <= '0;
            last_q         <= '0;
            len_q          <= ITER_W'(1);
            iter_q         <= '0;
            drain_q        <= '0;
            bus.pe_cfg_o   <= '0;
            bus.cfg_load_o <= 1'b0;
            bus.pea_en_o   <= 1'b0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
            bus.cfg_err_o  <= 1'b0;
        end else begin
            if (start_acc) last_q <= last_d;
            // LOAD lasts one cycle, so state_d == LOAD always marks the entering edge
            if (state_d == LOAD) begin
                ctx_q        <= load_ctx;
                len_q        <= rd_len;
                bus.pe_cfg_o <= rd_cfg;
            end
            if (state_q == LOAD)                                    iter_q <= '0;
            else if (state_q == RUN && bus.iter_done_i && !bus.abort_i) iter_q <= iter_q + 1'b1;
            drain_q        <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
            bus.cfg_load_o <= cfg_load_d;
            bus.pea_en_o   <= pea_en_d;
            bus.busy_o     <= busy_d;
            bus.done_o     <= done_d;
            bus.cfg_err_o  <= err_d;
        end
    end

    assign bus.ctx_idx_o = ctx_q;

endmodule

// File: tb/tb_pea_ctx_ctrl.sv
// Directed bench for pea_ctx_ctrl (N_CTX=4, ITER_W=16, DRAIN_CYCLES=2).
module tb_pea_ctx_ctrl;
    import pea_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    pea_ctx_ctrl_if #(.N_CTX(4), .ITER_W(16)) bus ();

    pea_ctx_ctrl #(.N_CTX(4), .ITER_W(16), .DRAIN_CYCLES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write one PE word and a length into a context in the same cycle
    task automatic wr(input int c, input int p, input logic [15:0] w, input logic [15:0] l);
        bus.cfg_we_i     = 1'b1;
        bus.cfg_len_we_i = 1'b1;
        bus.cfg_ctx_i    = 2'(c);
        bus.cfg_pe_i     = 4'(p);
        bus.cfg_wdata_i  = w;
        bus.cfg_len_i    = l;
        tick();
        bus.cfg_we_i     = 1'b0;
        bus.cfg_len_we_i = 1'b0;
        chk("wr_err", bus.cfg_err_o, 0);
    endtask

    // Called right after the edge that enters LOAD for context c; returns after
    // the edge leaving DRAIN (next LOAD), or after DONE has gone back to IDLE.
    task automatic ctx_pass(input int c, input logic [15:0] w0, input int nit, input bit last);
        chk("load_pulse", bus.cfg_load_o, 1);
        chk("load_busy", bus.busy_o, 1);
        chk("load_en", bus.pea_en_o, 0);
        chk("load_ctx", bus.ctx_idx_o, c);
        chk("load_pe0", bus.pe_cfg_o[15:0], w0);
        tick();
        chk("run_en", bus.pea_en_o, 1);
        chk("run_load", bus.cfg_load_o, 0);
        for (int i = 0; i < nit; i++) begin
            bus.iter_done_i = 1'b1;
            tick();
            if (i < nit - 1) chk("run_en_mid", bus.pea_en_o, 1);
            else             chk("drain_en", bus.pea_en_o, 0);
        end
        bus.iter_done_i = 1'b0;
        tick();
        chk("drain2_en", bus.pea_en_o, 0);
        chk("drain2_busy", bus.busy_o, 1);
        chk("drain2_load", bus.cfg_load_o, 0);
        chk("drain2_done", bus.done_o, 0);
        tick();
        if (last) begin
            chk("done_pulse", bus.done_o, 1);
            chk("done_busy", bus.busy_o, 1);
            tick();
            chk("idle_done", bus.done_o, 0);
            chk("idle_busy", bus.busy_o, 0);
        end
    endtask

    initial begin
        bus.cfg_we_i = 0; bus.cfg_len_we_i = 0; bus.cfg_ctx_i = '0; bus.cfg_pe_i = '0;
        bus.cfg_wdata_i = '0; bus.cfg_len_i = '0; bus.start_i = 0; bus.n_ctx_i = '0;
        bus.abort_i = 0; bus.iter_done_i = 0;

        // Reset state
        tick(); tick();
        chk("rst_pe_cfg", bus.pe_cfg_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_en", bus.pea_en_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_load", bus.cfg_load_o, 0);
        chk("rst_err", bus.cfg_err_o, 0);
        chk("rst_ctx", bus.ctx_idx_o, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy0", bus.busy_o, 0);

        // Single context, PE5 word, three iterations
        wr(0, 5, 16'h1A03, 16'd3);
        bus.start_i = 1; bus.n_ctx_i = 3'd1;
        tick();
        bus.start_i = 0;
        chk("t2_pe5", bus.pe_cfg_o[95:80], 16'h1A03);
        ctx_pass(0, 16'h0000, 3, 1'b1);

        // Three contexts; a write during the sequence is rejected
        wr(0, 0, 16'h1111, 16'd1);
        wr(1, 0, 16'h2222, 16'd2);
        wr(2, 0, 16'h3333, 16'd1);
        bus.start_i = 1; bus.n_ctx_i = 3'd3;
        tick();
        bus.start_i = 0;
        chk("t3_load", bus.cfg_load_o, 1);
        chk("t3_ctx0", bus.ctx_idx_o, 0);
        chk("t3_pe0", bus.pe_cfg_o[15:0], 16'h1111);
        chk("t3_pe5", bus.pe_cfg_o[95:80], 16'h1A03);
        bus.cfg_we_i = 1; bus.cfg_len_we_i = 1; bus.cfg_ctx_i = 2'd1; bus.cfg_pe_i = 4'd0;
        bus.cfg_wdata_i = 16'hDEAD; bus.cfg_len_i = 16'd5;
        tick();
        bus.cfg_we_i = 0; bus.cfg_len_we_i = 0;
        chk("t3_err", bus.cfg_err_o, 1);
        chk("t3_run_en", bus.pea_en_o, 1);
        bus.iter_done_i = 1;
        tick();
        bus.iter_done_i = 0;
        chk("t3_err_clr", bus.cfg_err_o, 0);
        chk("t3_drain_en", bus.pea_en_o, 0);
        tick(); tick();
        ctx_pass(1, 16'h2222, 2, 1'b0);
        ctx_pass(2, 16'h3333, 1, 1'b1);

        // Abort in RUN of ctx1 together with iter_done
        bus.start_i = 1; bus.n_ctx_i = 3'd3;
        tick();
        bus.start_i = 0;
        ctx_pass(0, 16'h1111, 1, 1'b0);
        chk("ab_ctx1", bus.ctx_idx_o, 1);
        tick();
        chk("ab_run_en", bus.pea_en_o, 1);
        bus.abort_i = 1; bus.iter_done_i = 1;
        tick();
        bus.abort_i = 0; bus.iter_done_i = 0;
        chk("ab_busy", bus.busy_o, 0);
        chk("ab_en", bus.pea_en_o, 0);
        chk("ab_done", bus.done_o, 0);
        tick();
        chk("ab_done2", bus.done_o, 0);
        chk("ab_busy2", bus.busy_o, 0);

        // n_ctx=0 ignored
        bus.start_i = 1; bus.n_ctx_i = 3'd0;
        tick();
        bus.start_i = 0;
        chk("n0_busy", bus.busy_o, 0);
        chk("n0_load", bus.cfg_load_o, 0);
        tick();
        chk("n0_busy2", bus.busy_o, 0);

        // Length 0 stored as 1; n_ctx=7 clamps to 4; write with start is dropped
        wr(3, 0, 16'h4444, 16'd0);
        bus.start_i = 1; bus.n_ctx_i = 3'd7;
        bus.cfg_we_i = 1; bus.cfg_ctx_i = 2'd3; bus.cfg_pe_i = 4'd0; bus.cfg_wdata_i = 16'hBEEF;
        tick();
        bus.start_i = 0; bus.cfg_we_i = 0;
        chk("st_wr_err", bus.cfg_err_o, 1);
        ctx_pass(0, 16'h1111, 1, 1'b0);
        ctx_pass(1, 16'h2222, 2, 1'b0);
        ctx_pass(2, 16'h3333, 1, 1'b0);
        ctx_pass(3, 16'h4444, 1, 1'b1);

        // Reset mid-sequence: no done, store cleared
        bus.start_i = 1; bus.n_ctx_i = 3'd1;
        tick();
        bus.start_i = 0;
        tick();
        chk("mr_en", bus.pea_en_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_en0", bus.pea_en_o, 0);
        chk("mr_pe_cfg", bus.pe_cfg_o, 0);
        chk("mr_ctx", bus.ctx_idx_o, 0);
        tick();
        chk("mr_done", bus.done_o, 0);
        bus.start_i = 1; bus.n_ctx_i = 3'd1;
        tick();
        bus.start_i = 0;
        chk("mr_cleared", bus.pe_cfg_o, 0);
        ctx_pass(0, 16'h0000, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pea_ctx_ctrl.md
Name: pea_ctx_ctrl

Overview:
Context sequencer for the MxN PEA. It stores up to N_CTX full-array configuration contexts, each holding one N_CFG_BITS_PE word per PE plus an iteration count. On start it drives the PEA through contexts 0..n_ctx-1. For each context it loads the configuration, enables the array for the programmed number of iterations, then drains the pipeline before switching. It sits between the host/config bus and the PEA configuration inputs.

Parameters:
N_CTX, 4, number of stored contexts (>=1)
ITER_W, 16, iteration-count width
DRAIN_CYCLES, 2, idle cycles after a context's last iteration before reconfiguring (0 allowed)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cfg_we_i  in  1  write a PE word into a context
cfg_len_we_i  in  1  write a context iteration count
cfg_ctx_i  in  $clog2(N_CTX) (min 1)  target context for either write
cfg_pe_i  in  LOG_M+LOG_N  target PE, row-major: row*N+col
cfg_wdata_i  in  N_CFG_BITS_PE  PE config word
cfg_len_i  in  ITER_W  iteration count
cfg_err_o  out  1  pulse: write rejected
start_i  in  1  start sequence
n_ctx_i  in  $clog2(N_CTX)+1  contexts to run
abort_i  in  1  abort sequence
iter_done_i  in  1  PEA pulse: one iteration completed
pe_cfg_o  out  M*N*N_CFG_BITS_PE  active config; PE k occupies bits [k*16 +: 16]
cfg_load_o  out  1  pulse: pe_cfg_o just changed
pea_en_o  out  1  PEA enable
ctx_idx_o  out  $clog2(N_CTX) (min 1)  active context
busy_o  out  1  state != IDLE
done_o  out  1  pulse: sequence complete

Behaviour:
- Reset clears:
  - all outputs to 0;
  - every context word to 0;
  - every length to 1;
  - FSM state to IDLE.
  - Reset mid-sequence aborts immediately, with no done_o.
- All outputs are registered.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE
  - Config writes commit on the clock edge. cfg_we_i and cfg_len_we_i may both be asserted in the same cycle; both commit.
  - start_i with n_ctx_i != 0 goes to LOAD with ctx_idx=0. Effective count = min(n_ctx_i, N_CTX).
  - start_i with n_ctx_i == 0 is ignored.
  - A write in the same cycle as an accepted start is dropped, and cfg_err_o pulses the next cycle.
- Writes outside IDLE are dropped, and cfg_err_o pulses 1 cycle later.
- Length 0 is stored as 1.
- LOAD (1 cycle)
  - pe_cfg_o holds the current context's words and cfg_load_o=1; both are registered on the entering edge.
  - Iteration counter is cleared.
  - Next state is RUN.
- RUN
  - pea_en_o=1.
  - Each iter_done_i increments the counter.
  - iter_done_i arriving when counter == len-1 goes to DRAIN, and pea_en_o=0 from the next cycle.
  - iter_done_i outside RUN is ignored.
- DRAIN
  - Lasts DRAIN_CYCLES cycles, or 0 cycles when DRAIN_CYCLES=0 (RUN exits directly to the successor).
  - Successor is DONE if ctx_idx == effective count - 1. Otherwise ctx_idx+1 and LOAD.
- DONE (1 cycle)
  - done_o=1, then IDLE.
  - pe_cfg_o keeps the last context.
- abort_i in any non-IDLE state
  - IDLE next cycle, pea_en_o=0, no done_o.
  - abort_i has priority over iter_done_i in the same cycle.
- ctx_idx_o updates on the edge that enters LOAD.
- busy_o=1 in LOAD, RUN, DRAIN and DONE.
- Minimum per-context latency from LOAD entry to next LOAD entry = 1 + len iteration pulses + DRAIN_CYCLES.

Decomposition:
- Add to pea_pkg:
  - ctx_state_t enum {IDLE, LOAD, RUN, DRAIN, DONE};
  - N_CTX_DEFAULT;
  - DRAIN_CYCLES_DEFAULT;
  - packed pe_cfg_t (N_CFG_BITS_PE wide) giving the word type.
- One sub-module: pea_ctx_store. It holds the N_CTX x M*N register file and the lengths, has a single write port, and provides a combinational read of a full context plus its length. The FSM lives in pea_ctx_ctrl.

Test Plan:
- Reset then idle: all outputs 0; busy_o=0; pe_cfg_o=0.
- Write ctx0 PE5 word 0x1A03 and ctx0 len 3, start with n_ctx=1, then three iter_done_i pulses:
  - cfg_load_o pulses once;
  - pe_cfg_o[95:80]=0x1A03;
  - pea_en_o high until the 3rd pulse;
  - 2 drain cycles;
  - done_o pulses once;
  - busy_o=0.
- Program ctx0/1/2 with lens 1/2/1 and distinct words, start with n_ctx=3: ctx_idx_o steps 0→1→2; 3 cfg_load_o pulses; done_o after 4 iter_done_i pulses.
- Write during RUN to ctx1: cfg_err_o pulses; ctx1 contents unchanged when later loaded.
- abort_i asserted in RUN of ctx1 together with iter_done_i: IDLE next cycle; no done_o; pea_en_o=0.
- start with n_ctx=0, then n_ctx=7 with N_CTX=4, then len written as 0:
  - n_ctx=0: no response;
  - n_ctx=7: runs exactly 4 contexts;
  - len 0: that context completes after 1 iteration.
